// File: rtl/clock_pkg.sv
// clock_pkg: shared encodings and BCD limits for the digital clock time-setting logic.
//   state_t      : controller state, 3-bit encoding
//   FLD_*        : SetField codes driven to the display multiplexer
//   HOUR_MAX     : last legal BCD hour before wrap
//   MINSEC_MAX   : last legal BCD minute/second before wrap
package clock_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_H    = 3'd1,
        SET_M    = 3'd2,
        SET_S    = 3'd3,
        COMMIT_H = 3'd4,
        COMMIT_M = 3'd5,
        COMMIT_S = 3'd6
    } state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HOUR = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_SEC  = 2'd3;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: button, time-value, load and display signals of the time-setting controller.
//   BtnMode, BtnInc        : debounced one-cycle button pulses
//   Hour, Minute, Second   : current BCD time from the counter chain
//   EN                     : count enable to all time counters
//   LOAD_H, LOAD_M, LOAD_S : per-counter load strobes
//   DATA                   : shared BCD load value
//   SetField, Blink        : display multiplexer controls
//   master: environment side (drives buttons and time), slave: the controller
interface time_set_ctrl_if;

    logic       BtnMode;
    logic       BtnInc;
    logic [7:0] Hour;
    logic [7:0] Minute;
    logic [7:0] Second;
    logic       EN;
    logic       LOAD_H;
    logic       LOAD_M;
    logic       LOAD_S;
    logic [7:0] DATA;
    logic [1:0] SetField;
    logic       Blink;

    modport master (
        output BtnMode, BtnInc, Hour, Minute, Second,
        input  EN, LOAD_H, LOAD_M, LOAD_S, DATA, SetField, Blink
    );

    modport slave (
        input  BtnMode, BtnInc, Hour, Minute, Second,
        output EN, LOAD_H, LOAD_M, LOAD_S, DATA, SetField, Blink
    );

endinterface

// File: rtl/bcd_inc_wrap.sv
// bcd_inc_wrap: combinational two-digit BCD increment with wrap to 00 past a limit.
//   value : current BCD value {tens, units}
//   max   : last legal BCD value; value >= max wraps to 8'h00
//   next  : incremented BCD value
module bcd_inc_wrap (
    input  logic [7:0] value,
    input  logic [7:0] max,
    output logic [7:0] next
);

    // Comparing with >= also recovers from any out-of-range value.
    always_comb
        next = (value >= max)         ? 8'h00 :
               (value[3:0] == 4'd9)   ? {value[7:4] + 4'd1, 4'd0} :
                                        {value[7:4], value[3:0] + 4'd1};

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: freezes the clock counters, edits BCD shadow copies from button
// pulses, then writes them back one field at a time through LOAD/DATA.
//   Clk  : system clock, all state changes on posedge
//   RST  : asynchronous active-low reset
//   bus  : time_set_ctrl_if.slave (buttons, current time, EN/LOAD/DATA, SetField/Blink)
// Parameters:
//   LOAD_CYC  : cycles each LOAD_x is held high during commit (1..15)
//   TIMEOUT   : idle cycles in a SET state before the edit is abandoned
//   BLINK_DIV : cycles per Blink half-period
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned LOAD_CYC  = 2,
    parameter logic [31:0] TIMEOUT   = 32'd100_000_000,
    parameter logic [31:0] BLINK_DIV = 32'd25_000_000
) (
    input logic             Clk,
    input logic             RST,
    time_set_ctrl_if.slave  bus
);

    state_t      state;
    logic [7:0]  sh_h;
    logic [7:0]  sh_m;
    logic [7:0]  sh_s;
    logic [31:0] tcnt;
    logic [31:0] bcnt;
    logic [3:0]  lcnt;
    logic [7:0]  sel_val;
    logic [7:0]  sel_max;
    logic [7:0]  inc_val;
    logic        inc_ok;
    logic        load_last;

    // One incrementer shared by all fields, fed by the field being edited.
    always_comb begin
        sel_val   = (state == SET_H) ? sh_h : (state == SET_M) ? sh_m : sh_s;
        sel_max   = (state == SET_H) ? HOUR_MAX : MINSEC_MAX;
        inc_ok    = bus.BtnInc & ~bus.BtnMode;
        load_last = (lcnt == 4'(LOAD_CYC - 1));
    end

    bcd_inc_wrap u_inc (
        .value (sel_val),
        .max   (sel_max),
        .next  (inc_val)
    );

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state        <= RUN;
            bus.EN       <= 1'b1;
            bus.LOAD_H   <= 1'b0;
            bus.LOAD_M   <= 1'b0;
            bus.LOAD_S   <= 1'b0;
            bus.DATA     <= 8'h00;
            bus.SetField <= FLD_NONE;
            bus.Blink    <= 1'b0;
            sh_h         <= 8'h00;
            sh_m         <= 8'h00;
            sh_s         <= 8'h00;
            tcnt         <= '0;
            bcnt         <= '0;
            lcnt         <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.BtnMode) begin
                        sh_h         <= bus.Hour;
                        sh_m         <= bus.Minute;
                        sh_s         <= bus.Second;
                        state        <= SET_H;
                        bus.EN       <= 1'b0;
                        bus.SetField <= FLD_HOUR;
                        bus.Blink    <= 1'b1;
                        tcnt         <= '0;
                        bcnt         <= '0;
                    end
                end
                SET_H, SET_M, SET_S: begin
                    // An increment restarts a fully visible half-period.
                    if (inc_ok) begin
                        bus.Blink <= 1'b1;
                        bcnt      <= '0;
                    end else if (bcnt == BLINK_DIV - 32'd1) begin
                        bus.Blink <= ~bus.Blink;
                        bcnt      <= '0;
                    end else begin
                        bcnt <= bcnt + 32'd1;
                    end
                    tcnt <= (bus.BtnMode | bus.BtnInc) ? '0 : tcnt + 32'd1;
                    if (bus.BtnMode) begin
                        if (state == SET_H) begin
                            state        <= SET_M;
                            bus.SetField <= FLD_MIN;
                        end else if (state == SET_M) begin
                            state        <= SET_S;
                            bus.SetField <= FLD_SEC;
                        end else begin
                            state        <= COMMIT_H;
                            bus.SetField <= FLD_NONE;
                            bus.Blink    <= 1'b0;
                            bus.LOAD_H   <= 1'b1;
                            bus.DATA     <= sh_h;
                            lcnt         <= '0;
                        end
                    end else if (inc_ok) begin
                        if (state == SET_H) sh_h <= inc_val;
                        if (state == SET_M) sh_m <= inc_val;
                        if (state == SET_S) sh_s <= inc_val;
                    end else if (tcnt == TIMEOUT - 32'd1) begin
                        // Abandon the edit; counters resume from their frozen value.
                        state        <= RUN;
                        bus.EN       <= 1'b1;
                        bus.SetField <= FLD_NONE;
                        bus.Blink    <= 1'b0;
                    end
                end
                COMMIT_H, COMMIT_M, COMMIT_S: begin
                    // Strobe hand-over happens on one edge: no gap, no overlap.
                    if (load_last) begin
                        lcnt <= '0;
                        if (state == COMMIT_H) begin
                            state      <= COMMIT_M;
                            bus.LOAD_H <= 1'b0;
                            bus.LOAD_M <= 1'b1;
                            bus.DATA   <= sh_m;
                        end else if (state == COMMIT_M) begin
                            state      <= COMMIT_S;
                            bus.LOAD_M <= 1'b0;
                            bus.LOAD_S <= 1'b1;
                            bus.DATA   <= sh_s;
                        end else begin
                            state      <= RUN;
                            bus.LOAD_S <= 1'b0;
                            bus.EN     <= 1'b1;
                        end
                    end else begin
                        lcnt <= lcnt + 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: table-driven, directed and randomized checks of time_set_ctrl against a reference model.
module tb_time_set_ctrl;

    localparam int LC = 2;
    localparam int TO = 16;
    localparam int BD = 4;

    logic Clk;
    logic RST;
    int   n_chk;
    int   n_err;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .LOAD_CYC  (LC),
        .TIMEOUT   (32'(TO)),
        .BLINK_DIV (32'(BD))
    ) dut (
        .Clk (Clk),
        .RST (RST),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: mode 0 = running, 1..3 = editing that field, 4 = writing back.
    int         m_mode;
    int         m_sh [1:3];
    int         m_idle;
    int         m_bph;
    int         m_ccnt;
    logic       m_bl;
    logic [7:0] m_data;

    function automatic int dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] bcd(input int d);
        return 8'(((d / 10) << 4) | (d % 10));
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_sh[1] = 0;
        m_sh[2] = 0;
        m_sh[3] = 0;
        m_idle = 0;
        m_bph = 0;
        m_ccnt = 0;
        m_bl = 1'b0;
        m_data = 8'h00;
    endtask

    task automatic model_step(input bit mb, input bit ib);
        if (!RST) begin
            model_reset();
            return;
        end
        if (m_mode == 0) begin
            if (mb) begin
                m_sh[1] = dec(bus.Hour);
                m_sh[2] = dec(bus.Minute);
                m_sh[3] = dec(bus.Second);
                m_mode = 1;
                m_idle = 0;
                m_bl = 1'b1;
                m_bph = 0;
            end
        end else if (m_mode <= 3) begin
            if (ib && !mb) begin
                m_bl = 1'b1;
                m_bph = 0;
            end else begin
                m_bph++;
                if (m_bph == BD) begin
                    m_bl = ~m_bl;
                    m_bph = 0;
                end
            end
            if (mb) begin
                m_idle = 0;
                if (m_mode == 3) begin
                    m_mode = 4;
                    m_ccnt = 0;
                    m_bl = 1'b0;
                    m_data = bcd(m_sh[1]);
                end else begin
                    m_mode++;
                end
            end else if (ib) begin
                m_idle = 0;
                m_sh[m_mode] = (m_sh[m_mode] + 1) % ((m_mode == 1) ? 24 : 60);
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_mode = 0;
                    m_bl = 1'b0;
                end
            end
        end else begin
            m_ccnt++;
            if (m_ccnt == 3 * LC) m_mode = 0;
            else if (m_ccnt % LC == 0) m_data = bcd(m_sh[m_ccnt / LC + 1]);
        end
    endtask

    function automatic logic [15:0] model_vec();
        logic [2:0] ld;
        logic [1:0] sf;
        ld = (m_mode == 4) ? (3'b100 >> (m_ccnt / LC)) : 3'b000;
        sf = (m_mode >= 1 && m_mode <= 3) ? 2'(m_mode) : 2'd0;
        return {1'b0, m_mode == 0, ld, sf, m_bl, m_data};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive buttons for one cycle, advance the model on the same edge, compare mid-cycle.
    task automatic cyc(input bit mb, input bit ib);
        bus.BtnMode = mb;
        bus.BtnInc = ib;
        @(posedge Clk);
        model_step(mb, ib);
        @(negedge Clk);
        chk("model", {1'b0, bus.EN, bus.LOAD_H, bus.LOAD_M, bus.LOAD_S, bus.SetField, bus.Blink, bus.DATA},
            model_vec());
    endtask

    task automatic run_commit(output logic [7:0] h, output logic [7:0] m, output logic [7:0] s, output int nh);
        h = 8'hxx;
        m = 8'hxx;
        s = 8'hxx;
        nh = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.LOAD_H) begin h = bus.DATA; nh++; end
            if (bus.LOAD_M) m = bus.DATA;
            if (bus.LOAD_S) s = bus.DATA;
            cyc(1'b0, 1'b0);
        end
    endtask

    typedef struct {
        bit         mb;
        bit         ib;
        bit         en;
        logic [1:0] sf;
        logic [2:0] ld;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        int         nh;
        bit         saw;
        n_chk = 0;
        n_err = 0;
        RST = 1'b0;
        bus.BtnMode = 1'b0;
        bus.BtnInc = 1'b0;
        bus.Hour = 8'h13;
        bus.Minute = 8'h45;
        bus.Second = 8'h07;
        model_reset();

        tbl[0]  = '{1, 0, 0, 2'd1, 3'b000, 8'h00};
        tbl[1]  = '{0, 1, 0, 2'd1, 3'b000, 8'h00};
        tbl[2]  = '{1, 0, 0, 2'd2, 3'b000, 8'h00};
        tbl[3]  = '{1, 1, 0, 2'd3, 3'b000, 8'h00};
        tbl[4]  = '{0, 1, 0, 2'd3, 3'b000, 8'h00};
        tbl[5]  = '{1, 0, 0, 2'd0, 3'b100, 8'h14};
        tbl[6]  = '{0, 0, 0, 2'd0, 3'b100, 8'h14};
        tbl[7]  = '{0, 0, 0, 2'd0, 3'b010, 8'h45};
        tbl[8]  = '{0, 0, 0, 2'd0, 3'b010, 8'h45};
        tbl[9]  = '{0, 0, 0, 2'd0, 3'b001, 8'h08};
        tbl[10] = '{0, 0, 0, 2'd0, 3'b001, 8'h08};
        tbl[11] = '{0, 0, 1, 2'd0, 3'b000, 8'h08};

        repeat (2) @(negedge Clk);
        chk("reset", {1'b0, bus.EN, bus.LOAD_H, bus.LOAD_M, bus.LOAD_S, bus.SetField, bus.Blink, bus.DATA},
            16'h4000);
        RST = 1'b1;

        for (int k = 0; k < 12; k++) begin
            cyc(tbl[k].mb, tbl[k].ib);
            chk($sformatf("vec%0d", k), {bus.EN, bus.LOAD_H, bus.LOAD_M, bus.LOAD_S, bus.SetField, bus.DATA},
                {tbl[k].en, tbl[k].ld, tbl[k].sf, tbl[k].data});
        end

        // Hour 23 -> 00 and minute 59 -> 00 wraps.
        bus.Hour = 8'h23;
        bus.Minute = 8'h59;
        bus.Second = 8'h00;
        cyc(1, 0); cyc(0, 1); cyc(1, 0); cyc(0, 1); cyc(1, 0); cyc(1, 0);
        run_commit(h, m, s, nh);
        chk("wrap_hour", 16'(h), 16'h00);
        chk("wrap_min", 16'(m), 16'h00);
        chk("load_h_len", 16'(nh), 16'(LC));

        // Eleven increments from 09 reach 20 through the units carry.
        bus.Hour = 8'h09;
        cyc(1, 0);
        for (int k = 0; k < 11; k++) cyc(0, 1);
        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        run_commit(h, m, s, nh);
        chk("carry_hour", 16'(h), 16'h20);
        chk("carry_min", 16'(m), 16'h59);

        // Idle in SET_H until the edit is abandoned.
        saw = 1'b0;
        cyc(1, 0);
        for (int k = 1; k <= TO; k++) begin
            cyc(0, 0);
            saw |= bus.LOAD_H | bus.LOAD_M | bus.LOAD_S;
            if (k == TO - 1) chk("timeout_before", 16'(bus.EN), 16'h0);
            if (k == TO) chk("timeout_en", {bus.EN, bus.SetField}, 3'b100);
        end
        chk("timeout_noload", 16'(saw), 16'h0);

        // Reset in the middle of the minute strobe.
        cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0);
        cyc(0, 0); cyc(0, 0);
        chk("pre_rst_loadm", 16'(bus.LOAD_M), 16'h1);
        #2 RST = 1'b0;
        #1 chk("async_rst", {bus.EN, bus.LOAD_H, bus.LOAD_M, bus.LOAD_S, bus.SetField}, 6'b100000);
        model_reset();
        cyc(0, 0);
        RST = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0);
            saw |= bus.LOAD_S;
        end
        chk("rst_no_loads", 16'(saw), 16'h0);
        chk("rst_en_sf", {bus.EN, bus.SetField}, 3'b100);

        // Randomized buttons and time values against the model.
        for (int k = 0; k < 2000; k++) begin
            if (k % 40 == 0) begin
                bus.Hour = bcd(int'($urandom_range(0, 23)));
                bus.Minute = bcd(int'($urandom_range(0, 59)));
                bus.Second = bcd(int'($urandom_range(0, 59)));
            end
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Sequences manual time setting for the digital clock.
- Freezes the hour/minute/second counter chain (EN) and edits BCD shadow copies from two debounced button pulses.
- Writes the shadow values back through the counters' LOAD/DATA ports, one field at a time.
- Sits between the button debouncers and the CountHour / minute / second counter blocks.
- Also drives field-select and blink outputs for the display multiplexer.

Parameters:
- LOAD_CYC, 2: cycles each LOAD_x is held high during commit (1..15).
- TIMEOUT, 32'd100_000_000: Clk cycles without a button pulse in a SET state before the edit is abandoned.
- BLINK_DIV, 32'd25_000_000: Clk cycles per Blink half-period.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- RST  in  1  asynchronous, active-low reset.
- BtnMode  in  1  one-cycle debounced pulse: enter set / advance field / commit.
- BtnInc  in  1  one-cycle debounced pulse: increment the selected field.
- Hour  in  8  current BCD hour from the hour counter, {tens, units}, 00..23.
- Minute  in  8  current BCD minute, 00..59.
- Second  in  8  current BCD second, 00..59.
- EN  out  1  count enable to all time counters.
- LOAD_H  out  1  load strobe, hour counter.
- LOAD_M  out  1  load strobe, minute counter.
- LOAD_S  out  1  load strobe, second counter.
- DATA  out  8  BCD load value, shared by all three counters.
- SetField  out  2  0=none, 1=hour, 2=minute, 3=second; the field being edited.
- Blink  out  1  display blank toggle for the selected field; 0 in RUN.

Behaviour:
- Reset (RST=0, asynchronous): state=RUN, EN=1, LOAD_H=LOAD_M=LOAD_S=0, DATA=8'h00, SetField=0, Blink=0, shadows=8'h00, timeout and blink counters=0.
- States: RUN, SET_H, SET_M, SET_S, COMMIT_H, COMMIT_M, COMMIT_S.
- RUN: EN=1.
  - On BtnMode, copy Hour/Minute/Second into shH/shM/shS and go to SET_H.
  - EN drops in the same cycle as the transition (registered: low from the next edge).
- SET_x: EN=0, SetField = field index.
  - BtnInc increments the selected shadow in BCD.
  - Units 9 -> 0 with tens+1.
  - Hour wraps 23 -> 00; minute and second wrap 59 -> 00.
  - Shadows never hold a non-BCD or out-of-range value.
- BtnMode advances SET_H -> SET_M -> SET_S -> COMMIT_H.
- Simultaneous BtnMode and BtnInc: BtnMode wins; the increment is discarded.
- Timeout counter:
  - Cleared on any button pulse and on entry to SET_H.
  - Reaching TIMEOUT-1 in any SET state returns to RUN with EN=1 and no LOAD; the counters resume from their frozen value.
- COMMIT_H / COMMIT_M / COMMIT_S:
  - DATA = shH / shM / shS.
  - The matching LOAD_x is high for exactly LOAD_CYC cycles, then the next state follows.
  - DATA is valid from the first LOAD_x cycle through the last; there is no gap and no overlap between strobes.
  - Exactly one LOAD_x is high at any time.
  - EN stays 0 throughout.
- After COMMIT_S: RUN, EN=1 in the cycle after LOAD_S falls, SetField=0.
- Buttons during COMMIT are ignored.
- Total commit latency from the BtnMode pulse in SET_S to EN=1: 3*LOAD_CYC+1 cycles.
- Blink:
  - Toggles every BLINK_DIV cycles while SetField!=0.
  - Forced to 1 (visible) for one half-period after each BtnInc.
  - Forced to 0 in RUN and COMMIT.
- DATA holds its last value outside COMMIT.
- Reset mid-commit aborts immediately: no further LOAD, EN=1 after release.

Decomposition:
- Shared package clock_pkg holds:
  - State encoding localparams (3-bit).
  - Field codes FLD_NONE/HOUR/MIN/SEC.
  - BCD limits HOUR_MAX=8'h23 and MINSEC_MAX=8'h59.
- One sub-module, bcd_inc_wrap: combinational, inputs value[7:0] and max[7:0], output next[7:0].
  - Used three times, or once with the input muxed by SetField.
- Timeout and blink counters stay inline.

Test Plan:
- Reset, then Hour=8'h13, Minute=8'h45, Second=8'h07; pulse BtnMode -> EN=0, SetField=1, shadows 13/45/07.
- In SET_H with shH=8'h23, pulse BtnInc -> shH=8'h00; 11 BtnInc from 8'h09 -> 8'h20. In SET_M from 8'h59, one BtnInc -> 8'h00.
- Full pass with LOAD_CYC=2: commit shows LOAD_H high 2 cycles with DATA=shH, then LOAD_M, then LOAD_S; EN=1 seven cycles after the final BtnMode.
- BtnMode and BtnInc in the same cycle in SET_M -> state SET_S, shM unchanged.
- TIMEOUT=16, no buttons after entering SET_H -> RUN at cycle 16, no LOAD strobe seen, EN=1.
- Assert RST=0 during COMMIT_M mid-strobe -> LOAD_M=0 asynchronously, no LOAD_S ever, EN=1 and SetField=0 after release.
